// File: rtl/dnn_conv_lanes_if.sv
// Memory-side bundle of dnn_conv_lanes: activation read, weight read and result write
// ports, each a valid/ready handshake with a word address.
interface dnn_conv_lanes_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int LANES  = 4,
    parameter int ADDR_W = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [ADDR_W-1:0]         in_addr;
    logic [DATA_W-1:0]         in_rdata;

    logic                      wt_valid;
    logic                      wt_ready;
    logic [ADDR_W-1:0]         wt_addr;
    logic [LANES*DATA_W-1:0]   wt_rdata;

    logic                      out_valid;
    logic                      out_ready;
    logic [ADDR_W-1:0]         out_addr;
    logic [ACC_W-1:0]          out_wdata;

    // Compute core side: issues requests.
    modport master (
        output in_valid, in_addr,
        input  in_ready, in_rdata,
        output wt_valid, wt_addr,
        input  wt_ready, wt_rdata,
        output out_valid, out_addr, out_wdata,
        input  out_ready
    );

    // Memory side: answers requests.
    modport slave (
        input  in_valid, in_addr,
        output in_ready, in_rdata,
        input  wt_valid, wt_addr,
        output wt_ready, wt_rdata,
        input  out_valid, out_addr, out_wdata,
        output out_ready
    );
endinterface

// File: rtl/dnn_conv_lanes.sv
// Multi-lane DNN compute core: stride-1 unpadded convolution or fully-connected layer,
// LANES output channels per pass, with all loop counters and address generation local.
module dnn_conv_lanes #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int LANES  = 4,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_conv,
    input  logic               i_relu,
    input  logic [DIM_W-1:0]   i_cfg_c,
    input  logic [DIM_W-1:0]   i_cfg_h,
    input  logic [DIM_W-1:0]   i_cfg_w,
    input  logic [DIM_W-1:0]   i_cfg_r,
    input  logic [DIM_W-1:0]   i_cfg_s,
    input  logic [DIM_W-1:0]   i_cfg_m,
    output logic               o_busy,
    output logic               o_done,
    dnn_conv_lanes_if.master   io_mem
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW = 2 * DATA_W;
    localparam logic [DIM_W-1:0] DimOne = DIM_W'(1);
    localparam logic [31:0]      LanesW = 32'(LANES);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StFetch = 3'd2;
    localparam logic [2:0] StMac   = 3'd3;
    localparam logic [2:0] StWrite = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic [2:0]               r_state, w_state_d;
    logic [DIM_W-1:0]         r_cfg_c, r_cfg_h, r_cfg_w, r_cfg_r, r_cfg_s, r_cfg_m;
    logic [DIM_W-1:0]         w_cfg_c_d, w_cfg_h_d, w_cfg_w_d, w_cfg_r_d, w_cfg_s_d, w_cfg_m_d;
    logic                     r_relu, w_relu_d;
    logic [DIM_W-1:0]         r_cnt_g, r_cnt_p, r_cnt_q, r_cnt_c, r_cnt_r, r_cnt_s;
    logic [DIM_W-1:0]         w_cnt_g_d, w_cnt_p_d, w_cnt_q_d, w_cnt_c_d, w_cnt_r_d, w_cnt_s_d;
    logic [LW-1:0]            r_lane, w_lane_d;
    logic                     r_in_valid, w_in_valid_d;
    logic                     r_wt_valid, w_wt_valid_d;
    logic [DATA_W-1:0]        r_in_data, w_in_data_d;
    logic [LANES*DATA_W-1:0]  r_wt_data, w_wt_data_d;
    logic [ACC_W-1:0]         r_acc [LANES];
    logic [ACC_W-1:0]         w_acc_d [LANES];
    logic [PW-1:0]            w_prod [LANES];

    function automatic logic [ADDR_W-1:0] f_ext(input logic [DIM_W-1:0] v);
        return ADDR_W'(v);
    endfunction

    // Address arithmetic is done at ADDR_W width; wrap-around equals truncation.
    logic [ADDR_W-1:0] w_hw, w_rs, w_crs, w_q, w_pq;
    logic [31:0]       w_m;
    logic              w_zero, w_last_s, w_last_r, w_last_c, w_last_q, w_last_p, w_last_g;
    logic              w_lane_last, w_in_fire, w_wt_fire, w_out_fire;
    logic [ACC_W-1:0]  w_acc_sel;

    // Layer geometry, loop-end flags and handshake completions.
    always_comb begin
        w_hw  = f_ext(r_cfg_h) * f_ext(r_cfg_w);
        w_rs  = f_ext(r_cfg_r) * f_ext(r_cfg_s);
        w_crs = f_ext(r_cfg_c) * w_rs;
        w_q   = f_ext(r_cfg_w) - f_ext(r_cfg_s) + ADDR_W'(1);
        w_pq  = (f_ext(r_cfg_h) - f_ext(r_cfg_r) + ADDR_W'(1)) * w_q;
        w_m   = 32'(r_cnt_g) * LanesW + 32'(r_lane);
        // R=0 or S=0 leaves no window to sum over, so it is treated as no work as well.
        w_zero = (r_cfg_c == '0) || (r_cfg_m == '0) || (r_cfg_r == '0) || (r_cfg_s == '0) ||
                 (r_cfg_r > r_cfg_h) || (r_cfg_s > r_cfg_w);
        w_last_s = (r_cnt_s == r_cfg_s - DimOne);
        w_last_r = (r_cnt_r == r_cfg_r - DimOne);
        w_last_c = (r_cnt_c == r_cfg_c - DimOne);
        w_last_q = (r_cnt_q == r_cfg_w - r_cfg_s);
        w_last_p = (r_cnt_p == r_cfg_h - r_cfg_r);
        w_last_g = ((32'(r_cnt_g) + 32'd1) * LanesW) >= 32'(r_cfg_m);
        w_lane_last = (r_lane == LW'(LANES - 1)) || ((w_m + 32'd1) >= 32'(r_cfg_m));
        w_in_fire  = r_in_valid && io_mem.in_ready;
        w_wt_fire  = r_wt_valid && io_mem.wt_ready;
        w_out_fire = (r_state == StWrite) && io_mem.out_ready;
        w_acc_sel  = r_acc[r_lane];
    end

    // Full-width signed products of the latched activation with each lane's weight.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_prod[l] = {{DATA_W{r_in_data[DATA_W-1]}}, r_in_data} *
                        {{DATA_W{r_wt_data[l*DATA_W+DATA_W-1]}}, r_wt_data[l*DATA_W +: DATA_W]};
        end
    end

    // Next-state logic for the FSM, loop counters, read latches and accumulators.
    always_comb begin
        w_state_d    = r_state;
        w_cfg_c_d    = r_cfg_c;
        w_cfg_h_d    = r_cfg_h;
        w_cfg_w_d    = r_cfg_w;
        w_cfg_r_d    = r_cfg_r;
        w_cfg_s_d    = r_cfg_s;
        w_cfg_m_d    = r_cfg_m;
        w_relu_d     = r_relu;
        w_cnt_g_d    = r_cnt_g;
        w_cnt_p_d    = r_cnt_p;
        w_cnt_q_d    = r_cnt_q;
        w_cnt_c_d    = r_cnt_c;
        w_cnt_r_d    = r_cnt_r;
        w_cnt_s_d    = r_cnt_s;
        w_lane_d     = r_lane;
        w_in_valid_d = r_in_valid;
        w_wt_valid_d = r_wt_valid;
        w_in_data_d  = r_in_data;
        w_wt_data_d  = r_wt_data;
        for (int l = 0; l < LANES; l++) w_acc_d[l] = r_acc[l];

        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_d = StSetup;
                    w_cfg_c_d = i_cfg_c;
                    w_cfg_m_d = i_cfg_m;
                    // A fully-connected layer is a 1x1 convolution over a 1x1 image.
                    w_cfg_h_d = i_conv ? i_cfg_h : DimOne;
                    w_cfg_w_d = i_conv ? i_cfg_w : DimOne;
                    w_cfg_r_d = i_conv ? i_cfg_r : DimOne;
                    w_cfg_s_d = i_conv ? i_cfg_s : DimOne;
                    w_relu_d  = i_relu;
                    w_cnt_g_d = '0;
                    w_cnt_p_d = '0;
                    w_cnt_q_d = '0;
                    w_cnt_c_d = '0;
                    w_cnt_r_d = '0;
                    w_cnt_s_d = '0;
                    w_lane_d  = '0;
                    for (int l = 0; l < LANES; l++) w_acc_d[l] = '0;
                end
            end
            StSetup: begin
                if (w_zero) begin
                    w_state_d = StDone;
                end else begin
                    w_state_d    = StFetch;
                    w_in_valid_d = 1'b1;
                    w_wt_valid_d = 1'b1;
                end
            end
            StFetch: begin
                if (w_in_fire) begin
                    w_in_valid_d = 1'b0;
                    w_in_data_d  = io_mem.in_rdata;
                end
                if (w_wt_fire) begin
                    w_wt_valid_d = 1'b0;
                    w_wt_data_d  = io_mem.wt_rdata;
                end
                if ((!r_in_valid || io_mem.in_ready) && (!r_wt_valid || io_mem.wt_ready)) begin
                    w_state_d = StMac;
                end
            end
            StMac: begin
                for (int l = 0; l < LANES; l++) begin
                    w_acc_d[l] = r_acc[l] + {{(ACC_W-PW){w_prod[l][PW-1]}}, w_prod[l]};
                end
                w_state_d    = StFetch;
                w_in_valid_d = 1'b1;
                w_wt_valid_d = 1'b1;
                if (!w_last_s) begin
                    w_cnt_s_d = r_cnt_s + DimOne;
                end else begin
                    w_cnt_s_d = '0;
                    if (!w_last_r) begin
                        w_cnt_r_d = r_cnt_r + DimOne;
                    end else begin
                        w_cnt_r_d = '0;
                        if (!w_last_c) begin
                            w_cnt_c_d = r_cnt_c + DimOne;
                        end else begin
                            w_cnt_c_d    = '0;
                            w_state_d    = StWrite;
                            w_in_valid_d = 1'b0;
                            w_wt_valid_d = 1'b0;
                            w_lane_d     = '0;
                        end
                    end
                end
            end
            StWrite: begin
                if (w_out_fire) begin
                    if (!w_lane_last) begin
                        w_lane_d = r_lane + LW'(1);
                    end else begin
                        w_lane_d = '0;
                        for (int l = 0; l < LANES; l++) w_acc_d[l] = '0;
                        w_state_d    = StFetch;
                        w_in_valid_d = 1'b1;
                        w_wt_valid_d = 1'b1;
                        if (!w_last_q) begin
                            w_cnt_q_d = r_cnt_q + DimOne;
                        end else begin
                            w_cnt_q_d = '0;
                            if (!w_last_p) begin
                                w_cnt_p_d = r_cnt_p + DimOne;
                            end else begin
                                w_cnt_p_d = '0;
                                if (!w_last_g) begin
                                    w_cnt_g_d = r_cnt_g + DimOne;
                                end else begin
                                    w_state_d    = StDone;
                                    w_in_valid_d = 1'b0;
                                    w_wt_valid_d = 1'b0;
                                end
                            end
                        end
                    end
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any layer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cfg_c    <= '0;
            r_cfg_h    <= '0;
            r_cfg_w    <= '0;
            r_cfg_r    <= '0;
            r_cfg_s    <= '0;
            r_cfg_m    <= '0;
            r_relu     <= 1'b0;
            r_cnt_g    <= '0;
            r_cnt_p    <= '0;
            r_cnt_q    <= '0;
            r_cnt_c    <= '0;
            r_cnt_r    <= '0;
            r_cnt_s    <= '0;
            r_lane     <= '0;
            r_in_valid <= 1'b0;
            r_wt_valid <= 1'b0;
            r_in_data  <= '0;
            r_wt_data  <= '0;
            for (int l = 0; l < LANES; l++) r_acc[l] <= '0;
        end else begin
            r_state    <= w_state_d;
            r_cfg_c    <= w_cfg_c_d;
            r_cfg_h    <= w_cfg_h_d;
            r_cfg_w    <= w_cfg_w_d;
            r_cfg_r    <= w_cfg_r_d;
            r_cfg_s    <= w_cfg_s_d;
            r_cfg_m    <= w_cfg_m_d;
            r_relu     <= w_relu_d;
            r_cnt_g    <= w_cnt_g_d;
            r_cnt_p    <= w_cnt_p_d;
            r_cnt_q    <= w_cnt_q_d;
            r_cnt_c    <= w_cnt_c_d;
            r_cnt_r    <= w_cnt_r_d;
            r_cnt_s    <= w_cnt_s_d;
            r_lane     <= w_lane_d;
            r_in_valid <= w_in_valid_d;
            r_wt_valid <= w_wt_valid_d;
            r_in_data  <= w_in_data_d;
            r_wt_data  <= w_wt_data_d;
            for (int l = 0; l < LANES; l++) r_acc[l] <= w_acc_d[l];
        end
    end

    // Outputs decode from registered state/counters, so reset clears them at once.
    always_comb begin
        o_busy = (r_state != StIdle) && (r_state != StDone);
        o_done = (r_state == StDone);
        io_mem.in_valid  = r_in_valid;
        io_mem.wt_valid  = r_wt_valid;
        io_mem.out_valid = (r_state == StWrite);
        io_mem.in_addr   = f_ext(r_cnt_c) * w_hw +
                           (f_ext(r_cnt_p) + f_ext(r_cnt_r)) * f_ext(r_cfg_w) +
                           f_ext(r_cnt_q) + f_ext(r_cnt_s);
        io_mem.wt_addr   = f_ext(r_cnt_g) * w_crs + f_ext(r_cnt_c) * w_rs +
                           f_ext(r_cnt_r) * f_ext(r_cfg_s) + f_ext(r_cnt_s);
        io_mem.out_addr  = ADDR_W'(w_m) * w_pq + f_ext(r_cnt_p) * w_q + f_ext(r_cnt_q);
        io_mem.out_wdata = (r_relu && w_acc_sel[ACC_W-1]) ? '0 : w_acc_sel;
    end

endmodule

// File: tb/tb_dnn_conv_lanes.sv
// Directed bench for dnn_conv_lanes: vector table of small layers with hand-computed
// results, plus sequences for start-while-busy, reset mid-write and zero-work layers.
module tb_dnn_conv_lanes;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, conv = 1'b0, relu = 1'b0;
    logic [7:0] cfg_c = '0, cfg_h = '0, cfg_w = '0, cfg_r = '0, cfg_s = '0, cfg_m = '0;
    logic       busy, done;

    int checks = 0;
    int failures = 0;
    int ready_mode = 0;
    int done_cnt = 0;
    int vseen = 0;
    int wcount = 0;
    logic [15:0] wlog_addr [16];
    logic [31:0] wlog_data [16];
    logic [7:0]  act_mem [16];
    logic [31:0] wt_mem [16];

    dnn_conv_lanes_if #(.DATA_W(8), .ACC_W(32), .LANES(4), .ADDR_W(16)) mem_if ();

    dnn_conv_lanes #(
        .DATA_W(8), .ACC_W(32), .LANES(4), .ADDR_W(16), .DIM_W(8)
    ) u_dut (
        .clk(clk), .rst(rst), .i_start(start), .i_conv(conv), .i_relu(relu),
        .i_cfg_c(cfg_c), .i_cfg_h(cfg_h), .i_cfg_w(cfg_w), .i_cfg_r(cfg_r),
        .i_cfg_s(cfg_s), .i_cfg_m(cfg_m), .o_busy(busy), .o_done(done), .io_mem(mem_if)
    );

    always #5 clk = ~clk;

    assign mem_if.in_rdata = (mem_if.in_addr < 16'd16) ? act_mem[mem_if.in_addr[3:0]] : 8'h00;
    assign mem_if.wt_rdata = (mem_if.wt_addr < 16'd16) ? wt_mem[mem_if.wt_addr[3:0]] : 32'h0;

    typedef struct {
        bit               conv;
        bit               relu;
        bit               rnd;
        logic [7:0]       c, h, w, r, s, m;
        logic [8:0][7:0]  act;
        logic [3:0][31:0] wt;
        int               n_exp;
        logic [4:0][15:0] ea;
        logic [4:0][31:0] ed;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input bit cv, input bit rl, input bit rn,
                                input logic [7:0] c, input logic [7:0] h, input logic [7:0] w,
                                input logic [7:0] r, input logic [7:0] s, input logic [7:0] m,
                                input logic [71:0] act, input logic [127:0] wt, input int n,
                                input logic [79:0] ea, input logic [159:0] ed);
        vec_t v;
        v.conv = cv; v.relu = rl; v.rnd = rn;
        v.c = c; v.h = h; v.w = w; v.r = r; v.s = s; v.m = m;
        v.act = act; v.wt = wt; v.n_exp = n; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Memory-side ready generation, changed just after each rising edge.
    initial begin
        mem_if.in_ready  = 1'b1;
        mem_if.wt_ready  = 1'b1;
        mem_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    mem_if.in_ready  = 1'($urandom_range(0, 1));
                    mem_if.wt_ready  = 1'($urandom_range(0, 1));
                    mem_if.out_ready = 1'($urandom_range(0, 1));
                end
                2: begin
                    mem_if.in_ready  = 1'b1;
                    mem_if.wt_ready  = 1'b1;
                    mem_if.out_ready = 1'b0;
                end
                default: begin
                    mem_if.in_ready  = 1'b1;
                    mem_if.wt_ready  = 1'b1;
                    mem_if.out_ready = 1'b1;
                end
            endcase
        end
    end

    // Monitor on the falling edge: logs writes, counts done pulses, checks hold-while-stalled.
    logic        p_in = 1'b0, p_wt = 1'b0, p_out = 1'b0;
    logic [15:0] p_in_addr, p_wt_addr, p_out_addr;
    logic [31:0] p_out_data;
    always @(negedge clk) begin
        if (rst) begin
            p_in = 1'b0; p_wt = 1'b0; p_out = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (mem_if.in_valid || mem_if.wt_valid || mem_if.out_valid) vseen++;
            if (p_in)  chk("in_hold", {mem_if.in_valid, mem_if.in_addr}, {1'b1, p_in_addr});
            if (p_wt)  chk("wt_hold", {mem_if.wt_valid, mem_if.wt_addr}, {1'b1, p_wt_addr});
            if (p_out) chk("out_hold", {mem_if.out_valid, mem_if.out_addr, mem_if.out_wdata},
                           {1'b1, p_out_addr, p_out_data});
            if (mem_if.out_valid && mem_if.out_ready) begin
                if (wcount < 16) begin
                    wlog_addr[wcount] = mem_if.out_addr;
                    wlog_data[wcount] = mem_if.out_wdata;
                end
                wcount++;
            end
            p_in  = mem_if.in_valid && !mem_if.in_ready;
            p_wt  = mem_if.wt_valid && !mem_if.wt_ready;
            p_out = mem_if.out_valid && !mem_if.out_ready;
            p_in_addr  = mem_if.in_addr;
            p_wt_addr  = mem_if.wt_addr;
            p_out_addr = mem_if.out_addr;
            p_out_data = mem_if.out_wdata;
        end
    end

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 16; i++) begin
            act_mem[i] = (i < 9) ? v.act[i] : 8'h00;
            wt_mem[i]  = (i < 4) ? v.wt[i] : 32'h0;
        end
        ready_mode = v.rnd ? 1 : 0;
        conv = v.conv; relu = v.relu;
        cfg_c = v.c; cfg_h = v.h; cfg_w = v.w; cfg_r = v.r; cfg_s = v.s; cfg_m = v.m;
        wcount = 0;
        done_cnt = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_vec(input vec_t v, input int id);
        bit seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("v%0d_done_seen", id), 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_done_pulses", id), 64'(done_cnt), 64'd1);
        chk($sformatf("v%0d_busy_after", id), 64'(busy), 64'd0);
        chk($sformatf("v%0d_writes", id), 64'(wcount), 64'(v.n_exp));
        for (int k = 0; k < v.n_exp; k++) begin
            chk($sformatf("v%0d_addr%0d", id, k), 64'(wlog_addr[k]), 64'(v.ea[k]));
            chk($sformatf("v%0d_data%0d", id, k), 64'(wlog_data[k]), 64'(v.ed[k]));
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        load_vec(v);
        pulse_start();
        finish_vec(v, id);
    endtask

    initial begin
        // FC test: inputs [1,2,3]; m0 weights [1,1,1], m1 [-1,0,2]; lanes 2,3 carry junk.
        vecs[0] = mk(1'b0, 1'b0, 1'b0, 8'd3, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2,
                     72'({8'd3, 8'd2, 8'd1}),
                     128'({32'h0505_0201, 32'h0505_0001, 32'h0505_FF01}),
                     2, 80'({16'd1, 16'd0}), 160'({32'd5, 32'd6}));
        // Conv 3x3 image, 2x2 all-ones kernel: window sums.
        vecs[1] = mk(1'b1, 1'b0, 1'b0, 8'd1, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1,
                     {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                     {4{32'h0707_0701}},
                     4, 80'({16'd3, 16'd2, 16'd1, 16'd0}),
                     160'({32'd28, 32'd24, 32'd16, 32'd12}));
        // m1 weights all -1: -6 without relu, 0 with relu.
        vecs[2] = mk(1'b0, 1'b0, 1'b0, 8'd3, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2,
                     72'({8'd3, 8'd2, 8'd1}), 128'({3{32'h0505_FF01}}),
                     2, 80'({16'd1, 16'd0}), 160'({32'hFFFF_FFFA, 32'd6}));
        vecs[3] = mk(1'b0, 1'b1, 1'b0, 8'd3, 8'd1, 8'd1, 8'd1, 8'd1, 8'd2,
                     72'({8'd3, 8'd2, 8'd1}), 128'({3{32'h0505_FF01}}),
                     2, 80'({16'd1, 16'd0}), 160'({32'd0, 32'd6}));
        // Partial group M=5; H/W/R/S inputs non-1 but ignored in FC mode.
        vecs[4] = mk(1'b0, 1'b0, 1'b0, 8'd1, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5,
                     72'(8'd2), 128'({32'h0909_0904, 32'h0302_0100}),
                     5, {16'd4, 16'd3, 16'd2, 16'd1, 16'd0},
                     {32'd8, 32'd6, 32'd4, 32'd2, 32'd0});
        vecs[5] = vecs[0]; vecs[5].rnd = 1'b1;
        vecs[6] = vecs[1]; vecs[6].rnd = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valids", 64'({mem_if.in_valid, mem_if.wt_valid, mem_if.out_valid}), 64'd0);
        chk("rst_addrs", 64'({mem_if.in_addr, mem_if.wt_addr, mem_if.out_addr}), 64'd0);
        chk("rst_wdata", 64'(mem_if.out_wdata), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Second start while busy carries a different config and must be ignored.
        load_vec(vecs[1]);
        pulse_start();
        repeat (6) @(posedge clk);
        #1;
        conv = 1'b0; cfg_c = 8'd3; cfg_m = 8'd2;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_vec(vecs[1], 10);

        // Reset while a write is pending.
        load_vec(vecs[1]);
        ready_mode = 2;
        pulse_start();
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (mem_if.out_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("rstw_write_seen", 64'(seen), 64'd1);
        end
        #1 rst = 1'b1;
        #1;
        chk("rstw_busy_done", 64'({busy, done}), 64'd0);
        chk("rstw_valids", 64'({mem_if.in_valid, mem_if.wt_valid, mem_if.out_valid}), 64'd0);
        chk("rstw_addrs", 64'({mem_if.in_addr, mem_if.out_addr}), 64'd0);
        chk("rstw_wdata", 64'(mem_if.out_wdata), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ready_mode = 0;
        repeat (20) @(negedge clk);
        chk("rstw_no_write", 64'(wcount), 64'd0);
        chk("rstw_no_done", 64'(done_cnt), 64'd0);
        chk("rstw_idle", 64'(busy), 64'd0);

        // Fresh start after reset reproduces the conv results.
        run_vec(vecs[1], 11);

        // C=0: no memory traffic, done two cycles after start.
        conv = 1'b1; cfg_c = 8'd0; cfg_h = 8'd3; cfg_w = 8'd3; cfg_r = 8'd2; cfg_s = 8'd2;
        cfg_m = 8'd2;
        done_cnt = 0;
        vseen = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("zero_c1_done", 64'(done), 64'd0);
        chk("zero_c1_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("zero_c2_done", 64'(done), 64'd1);
        chk("zero_c2_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("zero_c3_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        chk("zero_no_valid", 64'(vseen), 64'd0);
        chk("zero_pulses", 64'(done_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dnn_conv_lanes.md
Name: dnn_conv_lanes

Overview:
- Parametrised successor to the single-channel DNN compute core behind the PCPI DNN coprocessor.
- Computes a stride-1, zero-padding convolution (or a fully-connected layer) over LANES output channels in parallel.
- Sequences all loop counters and address generation, and issues reads and writes over three valid/ready memory ports.
- Hosted by the PCPI wrapper, which drives start and the layer configuration and bridges the three ports to mem_*_0/1/2.

Parameters:
DATA_W, 8, signed activation/weight width
ACC_W, 32, signed accumulator and output word width
LANES, 4, output channels computed in parallel
ADDR_W, 16, word-address width of all ports
DIM_W, 8, width of each configuration dimension

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle command strobe
conv  in  1  1 = convolution, 0 = fully-connected
relu  in  1  clamp negative results to 0
cfg_c, cfg_h, cfg_w, cfg_r, cfg_s, cfg_m  in  DIM_W each  C, H, W, R, S, M
busy  out  1  high while a layer runs
done  out  1  one-cycle completion pulse
in_valid / in_ready  out / in  1  activation read handshake
in_addr  out  ADDR_W  activation word address
in_rdata  in  DATA_W  activation data
wt_valid / wt_ready  out / in  1  weight read handshake
wt_addr  out  ADDR_W  weight word address
wt_rdata  in  LANES*DATA_W  lane l at [l*DATA_W +: DATA_W]
out_valid / out_ready  out / in  1  result write handshake
out_addr  out  ADDR_W  result word address
out_wdata  out  ACC_W  result

Behaviour:
- Reset: asynchronous, active-high. Takes effect immediately. busy, done, in_valid, wt_valid, out_valid, all addresses, out_wdata and accumulators = 0; FSM = IDLE. Reset mid-layer aborts the layer; no done pulse is produced.
- Configuration and mode are captured when start is high in IDLE. start in any other state is ignored. busy rises the cycle after start.
- Output size: P = H-R+1, Q = W-S+1. With conv=0, H=W=R=S=1 (P=Q=1).
- Zero-work layers: if C=0, M=0, R>H or S>W, no memory access occurs; done pulses 2 cycles after start.
- Loop order, outermost first: group g in 0..ceil(M/LANES)-1, then p, then q, then c, then r, then s.
- Addresses:
  - in_addr = c*H*W + (p+r)*W + (q+s)
  - wt_addr = g*C*R*S + c*R*S + r*S + s
  - out_addr = m*P*Q + p*Q + q, where m = g*LANES + l
  - All addresses are truncated to ADDR_W.
- Handshakes:
  - A transfer completes in the cycle valid && ready. Read data is sampled in that same cycle.
  - valid stays high, and addr/wdata stay stable, until the transfer completes.
  - The activation and weight ports complete independently; each deasserts valid once its own transfer completes.
- FSM:
  - IDLE: wait for start.
  - FETCH: drive in_valid and wt_valid until both reads have completed.
  - MAC: acc[l] += sext(in) * sext(wt[l]) for every lane. Products are full 2*DATA_W width, sign-extended to ACC_W. Accumulation wraps modulo 2^ACC_W. Go to FETCH for the next (c,r,s) step, or to WRITE after the last step.
  - WRITE: write lanes l = 0..LANES-1 in order, one out_valid transfer each, skipping lanes with m >= M. out_wdata = relu ? max(acc,0) : acc. Then clear the accumulators and go to FETCH for the next (p,q), or to DONE.
  - DONE: done = 1 for one cycle, busy drops in the same cycle, then IDLE.
- Throughput with all ready signals held high: 2 cycles per MAC step, plus 1 cycle per valid lane write.
- Lanes with m >= M still compute, but their results are never written.

Test Plan:
1. FC mode, LANES=4: C=3, M=2, input [1,2,3], weights m0 [1,1,1], m1 [-1,0,2] -> exactly 2 writes: addr0 = 6, addr1 = 5; single done pulse; busy low afterwards.
2. Conv mode: C=1, H=W=3, R=S=2, M=1, input 1..9, all weights 1 -> 4 writes at addr 0..3 with values 12, 16, 24, 28.
3. ReLU: repeat test 1 with m1 weights [-1,-1,-1] -> addr1 = -6 with relu=0, and addr1 = 0 with relu=1.
4. Partial group: M=5, LANES=4, FC mode, C=1, input 2, weights equal to m -> 5 writes, addr m = 2m; lanes 5..7 of group 1 are never written.
5. Backpressure: tests 1 and 2 rerun with in_ready, wt_ready and out_ready randomly low (about 50%) -> identical results; addr/wdata stable while valid && !ready; no duplicate transfers.
6. Control edge cases:
   - start pulsed while busy -> ignored.
   - rst asserted during WRITE -> all valids, busy and done are 0 in the same cycle, and no write completes.
   - A fresh start after reset reproduces the test 2 results.
   - C=0 -> no valids asserted; done pulses 2 cycles after start.
